// File: rtl/sdram_pkg.sv
// Shared SDRAM constants: command encodings {cs_n,ras_n,cas_n,we_n}, bus widths, arbiter states.
package sdram_pkg;

   localparam int ADDR_W = 13;
   localparam int BA_W   = 2;

   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_PALL  = 4'b0010;
   localparam logic [3:0] CMD_AREF  = 4'b0001;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_MRS   = 4'b0000;

   typedef enum logic [4:0] {
      S_INIT  = 5'b00001,
      S_ARBIT = 5'b00010,
      S_AREF  = 5'b00100,
      S_WRITE = 5'b01000,
      S_READ  = 5'b10000
   } arb_state_t;

endpackage

// File: rtl/sdram_arbiter.sv
// Command-bus arbiter: init, then refresh > round-robin write/read; one-cycle registered grant pulses.
// Pins follow the owner's cmd/addr with no added latency; the owner holds the bus until its end flag.
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter logic [BA_W-1:0] BA_FIX = 2'b00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        init_cmd,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              flag_init_end,
   input  logic              aref_req,
   input  logic [3:0]        aref_cmd,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic              flag_aref_end,
   output logic              aref_en,
   input  logic              wr_req,
   input  logic [3:0]        wr_cmd,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              flag_wr_end,
   output logic              wr_en,
   input  logic              rd_req,
   input  logic [3:0]        rd_cmd,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              flag_rd_end,
   output logic              rd_en,
   output logic              sdram_cke,
   output logic              sdram_cs_n,
   output logic              sdram_ras_n,
   output logic              sdram_cas_n,
   output logic              sdram_we_n,
   output logic [BA_W-1:0]   sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              r_last_rd;
   logic              r_aref_en;
   logic              r_wr_en;
   logic              r_rd_en;
   logic [3:0]        w_cmd;
   logic [ADDR_W-1:0] w_addr;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_INIT:  if (flag_init_end) w_state_nxt = S_ARBIT;
         S_ARBIT: begin
            if (aref_req)             w_state_nxt = S_AREF;
            else if (wr_req && rd_req) w_state_nxt = r_last_rd ? S_WRITE : S_READ;
            else if (wr_req)          w_state_nxt = S_WRITE;
            else if (rd_req)          w_state_nxt = S_READ;
         end
         S_AREF:  if (flag_aref_end) w_state_nxt = S_ARBIT;
         S_WRITE: if (flag_wr_end)   w_state_nxt = S_ARBIT;
         S_READ:  if (flag_rd_end)   w_state_nxt = S_ARBIT;
         default: w_state_nxt = S_INIT;
      endcase
   end

   // Grants only ever leave S_ARBIT, so each enable is a single-cycle pulse on state entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_INIT;
         r_last_rd <= 1'b0;
         r_aref_en <= 1'b0;
         r_wr_en   <= 1'b0;
         r_rd_en   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_aref_en <= (r_state == S_ARBIT) && (w_state_nxt == S_AREF);
         r_wr_en   <= (r_state == S_ARBIT) && (w_state_nxt == S_WRITE);
         r_rd_en   <= (r_state == S_ARBIT) && (w_state_nxt == S_READ);
         if ((r_state == S_ARBIT) && (w_state_nxt == S_READ))
            r_last_rd <= 1'b1;
         else if ((r_state == S_ARBIT) && (w_state_nxt == S_WRITE))
            r_last_rd <= 1'b0;
      end
   end

   always_comb begin
      w_cmd  = CMD_NOP;
      w_addr = '0;
      if (!rst) begin
         case (r_state)
            S_INIT:  begin w_cmd = init_cmd; w_addr = init_addr; end
            S_AREF:  begin w_cmd = aref_cmd; w_addr = aref_addr; end
            S_WRITE: begin w_cmd = wr_cmd;   w_addr = wr_addr;   end
            S_READ:  begin w_cmd = rd_cmd;   w_addr = rd_addr;   end
            default: begin w_cmd = CMD_NOP;  w_addr = '0;        end
         endcase
      end
   end

   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
   assign sdram_addr = w_addr;
   assign sdram_ba   = BA_FIX;
   assign sdram_cke  = ~rst;
   assign aref_en    = r_aref_en & ~rst;
   assign wr_en      = r_wr_en & ~rst;
   assign rd_en      = r_rd_en & ~rst;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter against a bus-ownership reference model.
module tb_sdram_arbiter;
   import sdram_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [3:0]  init_cmd = '0, aref_cmd = '0, wr_cmd = '0, rd_cmd = '0;
   logic [12:0] init_addr = '0, aref_addr = '0, wr_addr = '0, rd_addr = '0;
   logic        flag_init_end = 1'b0, flag_aref_end = 1'b0, flag_wr_end = 1'b0, flag_rd_end = 1'b0;
   logic        aref_req = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
   logic        aref_en, wr_en, rd_en;
   logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_addr;

   sdram_arbiter dut (
      .clk(clk), .rst(rst),
      .init_cmd(init_cmd), .init_addr(init_addr), .flag_init_end(flag_init_end),
      .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
      .flag_aref_end(flag_aref_end), .aref_en(aref_en),
      .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
      .flag_wr_end(flag_wr_end), .wr_en(wr_en),
      .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
      .flag_rd_end(flag_rd_end), .rd_en(rd_en),
      .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
      .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
      .sdram_ba(sdram_ba), .sdram_addr(sdram_addr)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: who owns the bus, whether its grant is due this cycle,
   // and which data engine won the last read/write contest.
   typedef enum int {M_INIT, M_IDLE, M_AREF, M_WR, M_RD} owner_t;
   owner_t m_own      = M_INIT;
   bit     m_grant    = 1'b0;
   bit     m_read_won = 1'b0;
   int     init_wait  = 0;

   function automatic owner_t pick_winner();
      if (aref_req)              return M_AREF;
      if (wr_req && rd_req)      return m_read_won ? M_WR : M_RD;
      if (wr_req)                return M_WR;
      if (rd_req)                return M_RD;
      return M_IDLE;
   endfunction

   task automatic cycle();
      logic [3:0]  e_cmd;
      logic [12:0] e_addr;
      owner_t      nxt;
      #1;
      e_cmd  = CMD_NOP;
      e_addr = '0;
      if (!rst) begin
         case (m_own)
            M_INIT: begin e_cmd = init_cmd; e_addr = init_addr; end
            M_AREF: begin e_cmd = aref_cmd; e_addr = aref_addr; end
            M_WR:   begin e_cmd = wr_cmd;   e_addr = wr_addr;   end
            M_RD:   begin e_cmd = rd_cmd;   e_addr = rd_addr;   end
            default: ;
         endcase
      end
      chk("cmd",     {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, e_cmd);
      chk("addr",    sdram_addr, e_addr);
      chk("cke",     sdram_cke, !rst);
      chk("ba",      sdram_ba, 2'b00);
      chk("aref_en", aref_en, !rst && m_grant && m_own == M_AREF);
      chk("wr_en",   wr_en,   !rst && m_grant && m_own == M_WR);
      chk("rd_en",   rd_en,   !rst && m_grant && m_own == M_RD);
      @(posedge clk);
      if (rst) begin
         m_own      = M_INIT;
         m_grant    = 1'b0;
         m_read_won = 1'b0;
      end else begin
         nxt = m_own;
         case (m_own)
            M_INIT: if (flag_init_end) nxt = M_IDLE;
            M_IDLE: nxt = pick_winner();
            M_AREF: if (flag_aref_end) nxt = M_IDLE;
            M_WR:   if (flag_wr_end)   nxt = M_IDLE;
            M_RD:   if (flag_rd_end)   nxt = M_IDLE;
            default: nxt = M_INIT;
         endcase
         m_grant = (m_own == M_IDLE) && (nxt != M_IDLE);
         if (m_grant && nxt == M_RD) m_read_won = 1'b1;
         if (m_grant && nxt == M_WR) m_read_won = 1'b0;
         m_own = nxt;
      end
      @(negedge clk);
   endtask

   task automatic randomize_buses();
      init_cmd  = 4'($urandom); init_addr = 13'($urandom);
      aref_cmd  = 4'($urandom); aref_addr = 13'($urandom);
      wr_cmd    = 4'($urandom); wr_addr   = 13'($urandom);
      rd_cmd    = 4'($urandom); rd_addr   = 13'($urandom);
   endtask

   initial begin
      @(negedge clk);
      // Directed power-up: reset, then init completes at cycle 10.
      for (int i = 0; i < 16; i++) begin
         randomize_buses();
         rst           = (i < 2);
         flag_init_end = (i >= 10);
         cycle();
      end
      // Randomized traffic with occasional resets, biased toward mid-transfer.
      for (int i = 0; i < 4000; i++) begin
         randomize_buses();
         if (m_own == M_WR || m_own == M_RD || m_own == M_AREF)
            rst = ($urandom_range(0, 39) == 0);
         else
            rst = ($urandom_range(0, 299) == 0);
         if (rst)
            init_wait = $urandom_range(0, 12);
         else if (init_wait > 0)
            init_wait--;
         flag_init_end = (init_wait == 0) && !rst;
         if ($urandom_range(0, 9) == 0) aref_req = ~aref_req;
         if ($urandom_range(0, 3) == 0) wr_req   = ~wr_req;
         if ($urandom_range(0, 3) == 0) rd_req   = ~rd_req;
         flag_aref_end = ($urandom_range(0, 4) == 0);
         flag_wr_end   = ($urandom_range(0, 4) == 0);
         flag_rd_end   = ($urandom_range(0, 4) == 0);
         cycle();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Central command arbiter for the SDRAM controller. It sits directly upstream of the read, write, refresh and init engines.
- Sequences power-up init, then grants the SDRAM command bus to one engine at a time with a one-cycle enable pulse (aref_en/wr_en/rd_en).
- Muxes the granted engine's 4-bit command and 13-bit address onto the SDRAM pins.
- Priority: refresh > write/read. Write and read share round-robin fairness.

Parameters:
- ADDR_W, 13, SDRAM address width (row/col/A10)
- BA_W, 2, bank address width
- BA_FIX, 2'b00, constant bank driven on sdram_ba
- CMD_NOP, 4'b0111, {cs_n,ras_n,cas_n,we_n} idle encoding

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- init_cmd  in  4  init engine command
- init_addr  in  13  init engine address
- flag_init_end  in  1  init complete, level, stays high
- aref_req  in  1  refresh request, level
- aref_cmd  in  4  refresh engine command
- aref_addr  in  13  refresh engine address
- flag_aref_end  in  1  refresh done, 1-cycle pulse
- aref_en  out  1  refresh grant pulse
- wr_req  in  1  write request, level
- wr_cmd  in  4  write engine command
- wr_addr  in  13  write engine address
- flag_wr_end  in  1  write burst/segment done, pulse
- wr_en  out  1  write grant pulse
- rd_req  in  1  read request, level
- rd_cmd  in  4  read engine command
- rd_addr  in  13  read engine address
- flag_rd_end  in  1  read segment done, pulse
- rd_en  out  1  read grant pulse
- sdram_cke  out  1  clock enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
- sdram_ba  out  2  bank address
- sdram_addr  out  13  address pins

Behaviour:
- States are one-hot: S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ. Reset sets state to S_INIT and last_rd to 0.
- S_INIT:
  - Pins carry init_cmd/init_addr.
  - flag_init_end=1 -> S_ARBIT next cycle.
- S_ARBIT: pins carry CMD_NOP, addr 0. Decision in the same cycle, in priority order:
  - aref_req -> S_AREF.
  - Else wr_req & rd_req both high -> read if last_rd==0, else write.
  - Else wr_req -> S_WRITE.
  - Else rd_req -> S_READ.
  - Else stay in S_ARBIT.
- Grants:
  - aref_en/wr_en/rd_en are registered. Each is 1 for exactly the first cycle of its state, and 0 at all other times.
  - An engine may wait in its request state indefinitely for the grant.
  - The enable must never be high when the engine re-requests after a break, so a level grant is forbidden.
- last_rd: updated on entry to S_READ (set to 1) or S_WRITE (set to 0). Untouched by refresh.
- S_AREF / S_WRITE / S_READ:
  - Pins carry the owner's cmd/addr combinationally from the state register. No added latency; the engine's own register stage is the pin timing.
  - The matching flag_*_end=1 -> S_ARBIT next cycle.
  - Flags from non-owners are ignored.
- No preemption: aref_req arriving during S_WRITE/S_READ is not acted on by the arbiter. The engine breaks itself, pulses flag_*_end and re-requests.
- Minimum one S_ARBIT cycle between any two grants. A request present in the same cycle as flag_*_end is granted no earlier than 2 cycles later.
- Pin mapping:
  - {sdram_cs_n,sdram_ras_n,sdram_cas_n,sdram_we_n} = selected cmd.
  - sdram_ba = BA_FIX.
  - sdram_cke = 1 whenever rst=0.
- Reset values, forced combinationally while rst=1:
  - Pins = CMD_NOP, sdram_addr 0, sdram_cke 0.
  - aref_en/wr_en/rd_en = 0.
- Reset mid-transfer: the state returns to S_INIT immediately and any pending grant is dropped. Engines are reset by the same rst.
- Unknown/illegal state -> S_INIT.

Decomposition:
- Shared package sdram_pkg holds:
  - Command constants CMD_NOP, CMD_PALL 4'b0010, CMD_AREF 4'b0001, CMD_WRITE 4'b0100, CMD_READ 4'b0101, CMD_ACT 4'b0011, CMD_MRS 4'b0000.
  - ADDR_W and BA_W.
  - Arbiter state encodings.
- No sub-module. The output mux stays inline; it is a single case on state.

Test Plan:
- Reset then flag_init_end at cycle 10 -> pins follow init_cmd through cycle 10, then NOP. State is S_ARBIT at cycle 11. No enables fire.
- rd_req held, flag_init_end=1 -> rd_en pulse width exactly 1, one cycle after rd_req seen in S_ARBIT. Pins follow rd_cmd (e.g. 4'b0011 then 4'b0101) until flag_rd_end.
- aref_req, wr_req and rd_req all high in S_ARBIT -> aref_en first. After flag_aref_end -> 1 ARBIT cycle, then rd_en (last_rd=0). After flag_rd_end -> wr_en (alternation).
- aref_req rises during S_READ -> no state change and no aref_en until flag_rd_end. aref_en follows 2 cycles after flag_rd_end.
- Read engine re-asserts rd_req in the cycle flag_rd_end pulses -> rd_en stays 0 that cycle and the next, then pulses once.
- rst asserted for 1 cycle while in S_WRITE -> next cycle pins = NOP, cke=0 during rst, all enables 0. State is S_INIT after rst deasserts.
